// File: rtl/seq101_pkg.sv
// Shared types and the single-step "101" overlapping Mealy detector transition
// used by the round-robin scheduler.
package seq101_pkg;

  typedef enum logic [1:0] {
    S   = 2'd0,
    S1  = 2'd1,
    S10 = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic       hit;
    seq_state_t next;
  } seq_step_t;

  // Encoding 2'b11 behaves like S: it can never raise a hit.
  function automatic seq_step_t seq_next(input seq_state_t cur, input logic x);
    seq_step_t r;
    r.hit  = 1'b0;
    r.next = x ? S1 : S;
    case (cur)
      S1:      r.next = x ? S1 : S10;
      S10: begin
        r.hit  = x;
        r.next = x ? S1 : S;
      end
      default: r.next = x ? S1 : S;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq101_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1 with
// wrap-around and grants the first requester.
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_any
);

  logic [W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N; k++) begin
      idx = W'((int'(ptr) + k) % N);
      if (!gnt_any && req[idx]) begin
        gnt_any      = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/seq101_rr_scheduler.sv
// One shared "101" detector time-multiplexed over N_CH serial streams; each
// channel keeps its own context, a round-robin arbiter picks one bit per cycle.
module seq101_rr_scheduler
  import seq101_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CW   = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic            en,
  input  logic [N_CH-1:0] in_valid,
  input  logic [N_CH-1:0] in_bit,
  output logic [N_CH-1:0] in_ready,
  input  logic [N_CH-1:0] chan_clr,
  output logic            hit_valid,
  output logic [CW-1:0]   hit_chan,
  output logic            busy_any
);

  seq_state_t      ctx     [N_CH];
  seq_state_t      ctx_nxt [N_CH];
  logic [N_CH-1:0] elig;
  logic [N_CH-1:0] gnt;
  logic [N_CH-1:0] busy_vec;
  logic [CW-1:0]   ptr;
  logic [CW-1:0]   gnt_idx;
  logic            gnt_any;
  seq_step_t       step;

  // A clearing channel is withheld so its source keeps the bit for later.
  assign elig = in_valid & ~chan_clr & {N_CH{en}};

  rr_arbiter #(.N(N_CH)) u_arb (
    .req     (elig),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign in_ready = gnt & {N_CH{aresetn}};
  assign step     = seq_next(ctx[gnt_idx], in_bit[gnt_idx]);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign ctx_nxt[i]  = chan_clr[i] ? S : (gnt[i] ? step.next : ctx[i]);
    assign busy_vec[i] = (ctx_nxt[i] != S);

    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) ctx[i] <= S;
      else          ctx[i] <= ctx_nxt[i];
    end
  end

  // Pointer resets to the last channel so channel 0 wins the first search.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ptr       <= CW'(N_CH - 1);
      hit_valid <= 1'b0;
      hit_chan  <= '0;
      busy_any  <= 1'b0;
    end else begin
      if (gnt_any) ptr <= gnt_idx;
      hit_valid <= gnt_any & step.hit;
      if (gnt_any & step.hit) hit_chan <= gnt_idx;
      busy_any  <= |busy_vec;
    end
  end

endmodule

// File: tb/tb_seq101_rr_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic compared against
// a bit-history reference model of the round-robin "101" scheduler.
module tb_seq101_rr_scheduler;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         aresetn = 1'b0;
  logic         en = 1'b0;
  logic [N-1:0] in_valid = '0;
  logic [N-1:0] in_bit = '0;
  logic [N-1:0] chan_clr = '0;
  logic [N-1:0] in_ready;
  logic         hit_valid;
  logic [1:0]   hit_chan;
  logic         busy_any;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: per channel, the number of bits seen since clear/reset
  // (saturating at 2) and the last two bits; a hit is "1","0" then a 1.
  int         mptr;
  int         mlen  [N];
  logic [1:0] mhist [N];

  always #5 clk = ~clk;

  seq101_rr_scheduler #(.N_CH(N)) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .en        (en),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .chan_clr  (chan_clr),
    .hit_valid (hit_valid),
    .hit_chan  (hit_chan),
    .busy_any  (busy_any)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mptr = N - 1;
    for (int i = 0; i < N; i++) begin
      mlen[i]  = 0;
      mhist[i] = 2'b00;
    end
  endtask

  function automatic logic model_busy();
    logic b;
    b = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (mlen[i] >= 1 && mhist[i][0]) b = 1'b1;
      if (mlen[i] >= 2 && mhist[i] == 2'b10) b = 1'b1;
    end
    return b;
  endfunction

  // Entered one time unit after a rising edge with inputs already driven.
  task automatic cycle();
    int         g;
    logic [N-1:0] er;
    logic       hv;
    #2;
    g = -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (mptr + k) % N;
      if (g < 0 && en && in_valid[c] && !chan_clr[c]) g = c;
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(er));
    @(posedge clk);
    hv = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (chan_clr[i]) begin
        mlen[i]  = 0;
        mhist[i] = 2'b00;
      end
    end
    if (g >= 0) begin
      hv       = (mlen[g] >= 2) && (mhist[g] == 2'b10) && in_bit[g];
      mhist[g] = {mhist[g][0], in_bit[g]};
      mlen[g]  = (mlen[g] >= 2) ? 2 : mlen[g] + 1;
      mptr     = g;
    end
    #1;
    chk("hit_valid", 32'(hit_valid), 32'(hv));
    if (hv) chk("hit_chan", 32'(hit_chan), 32'(g));
    chk("busy_any", 32'(busy_any), 32'(model_busy()));
  endtask

  task automatic drive(input logic e, input logic [N-1:0] v, input logic [N-1:0] b,
                       input logic [N-1:0] c);
    en       = e;
    in_valid = v;
    in_bit   = b;
    chan_clr = c;
    cycle();
  endtask

  task automatic full_reset();
    aresetn = 1'b0;
    model_reset();
    #1;
    chk("rst_hit_valid", 32'(hit_valid), 32'h0);
    chk("rst_hit_chan", 32'(hit_chan), 32'h0);
    chk("rst_busy", 32'(busy_any), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
  endtask

  initial begin
    en = 1'b1; in_valid = '1; in_bit = '1;
    model_reset();
    #1;
    chk("rst_in_ready_held", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    en = 1'b0; in_valid = '0; in_bit = '0;
    full_reset();

    // Single channel: ch0 gets 1,0,1 then idles.
    drive(1, 4'b0001, 4'b0001, 4'b0000);
    drive(1, 4'b0001, 4'b0000, 4'b0000);
    drive(1, 4'b0001, 4'b0001, 4'b0000);
    drive(1, 4'b0000, 4'b0000, 4'b0000);
    drive(1, 4'b0000, 4'b0000, 4'b0000);

    // Overlap on ch2: 1,0,1,0,1 gives two hits.
    for (int i = 0; i < 5; i++) drive(1, 4'b0100, (i % 2 == 0) ? 4'b0100 : 4'b0000, 4'b0000);
    drive(1, 4'b0000, 4'b0000, 4'b0000);

    // Round-robin interleave from reset: each channel sees 1,0,1 on its own grants.
    full_reset();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < N; c++) drive(1, 4'b1111, (r == 1) ? 4'b0000 : 4'b1111, 4'b0000);
    drive(1, 4'b0000, 4'b0000, 4'b0000);

    // Clear collision on ch1 sitting at S10.
    full_reset();
    drive(1, 4'b0010, 4'b0010, 4'b0000);
    drive(1, 4'b0010, 4'b0000, 4'b0000);
    drive(1, 4'b0010, 4'b0010, 4'b0010);
    drive(1, 4'b0010, 4'b0000, 4'b0000);
    drive(1, 4'b0010, 4'b0010, 4'b0000);
    drive(1, 4'b0010, 4'b0000, 4'b0000);
    drive(1, 4'b0010, 4'b0010, 4'b0000);
    drive(1, 4'b0000, 4'b0000, 4'b0000);

    // Enable gating with ch0 parked at S10, then resume to the hit.
    full_reset();
    drive(1, 4'b0001, 4'b0001, 4'b0000);
    drive(1, 4'b0001, 4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++) drive(0, 4'b1111, 4'b1111, 4'b0000);
    drive(1, 4'b0001, 4'b0001, 4'b0000);
    drive(1, 4'b0000, 4'b0000, 4'b0000);

    // Async reset mid-cycle with ch3 at S10; partial pattern must be lost.
    drive(1, 4'b1000, 4'b1000, 4'b0000);
    drive(1, 4'b1000, 4'b0000, 4'b0000);
    in_valid = 4'b1000; in_bit = 4'b1000;
    #2;
    aresetn = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_busy", 32'(busy_any), 32'h0);
    chk("mid_rst_hit", 32'(hit_valid), 32'h0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    drive(1, 4'b1000, 4'b1000, 4'b0000);
    drive(1, 4'b0000, 4'b0000, 4'b0000);

    // Skipping idle channels: only ch1 and ch3 request.
    full_reset();
    for (int i = 0; i < 6; i++) drive(1, 4'b1010, 4'($urandom), 4'b0000);

    // Random traffic with sparse clears and occasional enable drops.
    full_reset();
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 9) != 0, 4'($urandom), 4'($urandom),
            ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seq101_rr_scheduler.md
Name: seq101_rr_scheduler

Overview:
- Shares one "101" overlapping Mealy sequence-detector datapath among N_CH serial bit streams.
- Each channel keeps its own 2-bit detector context (S, S1, S10).
- A round-robin arbiter grants one channel per cycle, consumes one bit from it, advances that channel's context, and emits a registered hit tagged with the channel index.
- Sits between per-lane serial receivers and a shared event/interrupt collector.

Parameters:
- N_CH, 4, number of requesting channels; legal range 2..16.
- CW, $clog2(N_CH), width of channel index; localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- aresetn  input  1  reset, asynchronous assert, active-low.
- en  input  1  global enable; when 0 no grants issue, contexts hold.
- in_valid  input  N_CH  per-channel bit available.
- in_bit  input  N_CH  per-channel serial bit, sampled only on grant.
- in_ready  output  N_CH  one-hot (or zero) grant; a bit transfers when in_valid[i] & in_ready[i].
- chan_clr  input  N_CH  synchronous per-channel context clear.
- hit_valid  output  1  registered; 1 for one cycle per detected "101".
- hit_chan  output  CW  registered; channel index of the hit, valid when hit_valid=1.
- busy_any  output  1  registered; 1 if any channel context != S.

Behaviour:
- Reset (aresetn=0, asynchronous):
  - all contexts = S.
  - rr pointer = N_CH-1, so channel 0 has first priority.
  - hit_valid=0, hit_chan=0, busy_any=0.
  - in_ready is combinational and is 0 while aresetn=0.
- Reset released mid-stream: no bit is consumed in a cycle where aresetn=0; partial patterns are lost.
- Eligibility: channel i is eligible when en & in_valid[i] & !chan_clr[i].
- Grant (combinational, in the same cycle):
  - Search from (ptr+1) mod N_CH upward with wrap-around. The first eligible channel g gets in_ready[g]=1; all other in_ready bits are 0.
  - No eligible channel: in_ready=0, ptr holds.
- On the clock edge with a grant to g:
  - ptr <= g.
  - Context of g advances per x=in_bit[g]:
    - S: x ? S1 : S
    - S1: x ? S1 : S10
    - S10: x ? S1 : S
  - Hit condition (Mealy): ctx[g]==S10 & x==1. On a hit, next cycle hit_valid=1, hit_chan=g; otherwise hit_valid=0.
  - Latency: bit accepted in cycle t, hit visible in cycle t+1.
  - Overlap: "10101" on one channel gives two hits.
- Non-granted channels hold their context. Interleaving channels never corrupts another channel's partial pattern.
- chan_clr[i]=1:
  - ctx[i] <= S at the edge.
  - Channel i is not granted that cycle, so no bit is lost silently: in_ready[i]=0 and the source holds.
  - Clear of a non-granted channel coexists with a grant to another channel.
- en=0: in_ready=0, contexts hold except for chan_clr, hit_valid=0 next cycle.
- busy_any is registered from the next-state contexts (OR over ctx != S).
- Illegal context encoding (2'b11) is treated as S on the next grant and raises no hit.
- Fairness: a continuously valid channel waits at most N_CH-1 grants.

Decomposition:
- Shared package seq101_pkg:
  - typedef enum logic [1:0] {S=0, S1=1, S10=2} seq_state_t.
  - pure function seq_next(seq_state_t, logic x), returning {hit, next}.
- Sub-module rr_arbiter (parameter N): inputs req[N], ptr; output gnt[N] one-hot, gnt_idx; purely combinational.
- Context array, ptr and output registers live in seq101_rr_scheduler.

Test Plan:
- Reset and single channel (N_CH=4): reset, then ch0 only valid with bits 1,0,1 on three consecutive grants -> hit_valid=1, hit_chan=0 exactly one cycle after the third grant; busy_any=1 after the first bit; no other hits.
- Overlap: ch2 streams 1,0,1,0,1 -> two hits, both hit_chan=2, one cycle after grants 3 and 5.
- Round-robin interleave: all four valid every cycle -> in_ready sequence 0001,0010,0100,1000,0001. Each channel fed 1,0,1 on its own grants -> hits on ch0..ch3 in consecutive cycles 10..13 after start; no cross-channel corruption.
- Clear collision: ch1 at S10, assert chan_clr[1] with in_valid[1]=1, in_bit=1 -> in_ready[1]=0 that cycle, no hit, ch1 context=S; then 0,1 -> no hit; then 1,0,1 -> hit.
- Enable gating and async reset: en=0 for 5 cycles with all valid -> in_ready=0, contexts unchanged. Then en=1 resumes the pattern and the hit fires. Assert aresetn low mid-cycle with ch3 at S10 -> outputs drop immediately; after release, bit 1 on ch3 -> no hit.
- Skipping idle channels: only ch1 and ch3 valid, ptr=1 -> grant ch3, then ch1, then ch3; ch0 and ch2 never granted.
